bram_stream_reader: RTL and testbench

//  Read-side master for the 2-port synchronous BRAMs (registered read address, 1-cycle read latency).
//  On a start command it reads LEN words from port B, starting at BASE, and presents them in order on
//  a valid/ready stream. Used by SoC peripherals that unload frame/ROM buffers (UART TX, DMA out).

---
 rtl/bram_rd_pkg.sv | 14 +
 rtl/bram_rd_fifo3.sv | 66 ++++++
 rtl/bram_stream_reader.sv | 146 ++++++++++++++
 tb/tb_bram_stream_reader.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/bram_rd_pkg.sv
// rtl/bram_rd_pkg.sv - shared types and sizing helpers for the BRAM stream reader
package bram_rd_pkg;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

    localparam int BUF_DEPTH = 3;
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    // Word counts span 0..2**addr_w inclusive, so they need one bit more than an address.
    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/bram_rd_fifo3.sv
// rtl/bram_rd_fifo3.sv - 3-entry shift-register FIFO; head slot drives the stream directly
module bram_rd_fifo3 import bram_rd_pkg::*; #(
    parameter int DATA = 8
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic [DATA-1:0]  push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [OCC_W-1:0] occ,
    output logic [DATA-1:0]  head_data,
    output logic             head_valid
);

    logic [BUF_DEPTH-1:0][DATA-1:0] data_q, data_n;
    logic [BUF_DEPTH-1:0]           vld_q, vld_n;
    logic                           placed;

    // Valid slots are always contiguous from slot 0, so a pop is a shift down
    // and a push lands in the first free slot after that shift.
    always_comb begin
        data_n = data_q;
        vld_n  = vld_q;
        placed = 1'b0;
        if (pop) begin
            for (int i = 0; i < BUF_DEPTH - 1; i++) begin
                data_n[i] = data_q[i+1];
                vld_n[i]  = vld_q[i+1];
            end
            vld_n[BUF_DEPTH-1] = 1'b0;
        end
        if (push) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                if (!placed && !vld_n[i]) begin
                    vld_n[i]  = 1'b1;
                    data_n[i] = push_data;
                    placed    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            data_q <= '0;
            vld_q  <= '0;
        end else if (flush) begin
            vld_q  <= '0;
        end else begin
            data_q <= data_n;
            vld_q  <= vld_n;
        end
    end

    always_comb begin
        if (vld_q[2])      occ = OCC_W'(3);
        else if (vld_q[1]) occ = OCC_W'(2);
        else if (vld_q[0]) occ = OCC_W'(1);
        else               occ = OCC_W'(0);
    end

    assign head_data  = data_q[0];
    assign head_valid = vld_q[0];

endmodule

// File: rtl/bram_stream_reader.sv
// rtl/bram_stream_reader.sv - reads LEN words from a 1-cycle-latency BRAM port onto a valid/ready stream
// Optional build macro BRAM_RD_LOOP_EN adds the 'loop' input for continuous re-reading of the window.
module bram_stream_reader import bram_rd_pkg::*; #(
    parameter int ADDR = 10,
    parameter int DATA = 8
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            start,
    input  logic [ADDR-1:0] base,
    input  logic [ADDR:0]   len,
    input  logic            abort,
`ifdef BRAM_RD_LOOP_EN
    input  logic            loop,
`endif
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] ram_addr,
    input  logic [DATA-1:0] ram_read,
    output logic [DATA-1:0] m_data,
    output logic            m_valid,
    input  logic            m_ready
);

    localparam int CW = cnt_w(ADDR);

    state_t           state;
    logic [CW-1:0]    remaining;
    logic             inflight;
    logic             issue;
    logic             pop;
    logic             drain_last;
    logic [OCC_W-1:0] occ;

`ifdef BRAM_RD_LOOP_EN
    logic [ADDR-1:0]  base_r;
    logic [CW-1:0]    len_r;
    logic [CW-1:0]    pass_cnt;
    logic             pass_end;

    assign pass_end = pop && (pass_cnt == len_r - CW'(1));
`endif

    // Issue decision uses only registered counts so m_ready never reaches ram_addr.
    assign issue      = (state == S_RUN) && !abort && ((int'(occ) + int'(inflight)) < BUF_DEPTH);
    assign pop        = m_valid && m_ready;
    assign drain_last = !inflight && ((occ == OCC_W'(0)) || ((occ == OCC_W'(1)) && pop));

    bram_rd_fifo3 #(.DATA(DATA)) u_fifo (
        .clk        (clk),
        .nreset     (nreset),
        .push       (inflight),
        .push_data  (ram_read),
        .pop        (pop),
        .flush      (abort),
        .occ        (occ),
        .head_data  (m_data),
        .head_valid (m_valid)
    );

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ram_addr  <= '0;
            remaining <= '0;
            inflight  <= 1'b0;
`ifdef BRAM_RD_LOOP_EN
            base_r    <= '0;
            len_r     <= '0;
            pass_cnt  <= '0;
`endif
        end else if (abort) begin
            // Clearing inflight discards any word the RAM returns next cycle.
            state    <= S_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            done     <= 1'b0;
`ifdef BRAM_RD_LOOP_EN
            if (pop) pass_cnt <= pass_end ? '0 : pass_cnt + CW'(1);
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ram_addr  <= base;
                        remaining <= len;
                        busy      <= 1'b1;
`ifdef BRAM_RD_LOOP_EN
                        base_r    <= base;
                        len_r     <= len;
                        pass_cnt  <= '0;
`endif
                        if (len == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
`ifdef BRAM_RD_LOOP_EN
                    done <= pass_end;
`endif
                    if (issue) begin
                        ram_addr  <= ram_addr + ADDR'(1);
                        remaining <= remaining - CW'(1);
                        if (remaining == CW'(1)) begin
`ifdef BRAM_RD_LOOP_EN
                            if (loop) begin
                                ram_addr  <= base_r;
                                remaining <= len_r;
                            end else begin
                                state <= S_DRAIN;
                            end
`else
                            state <= S_DRAIN;
`endif
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_last) begin
                        state <= S_FIN;
                        done  <= 1'b1;
                    end
`ifdef BRAM_RD_LOOP_EN
                    else begin
                        done <= pass_end;
                    end
`endif
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// tb/tb_bram_stream_reader.sv - scoreboard bench for bram_stream_reader with a 1-cycle BRAM model
module tb_bram_stream_reader;

    localparam int ADDR = 10;
    localparam int DATA = 8;

    logic            clk = 1'b0;
    logic            nreset, start, abort, m_ready;
    logic            busy, done, m_valid;
    logic [ADDR-1:0] base, ram_addr;
    logic [ADDR:0]   len;
    logic [DATA-1:0] ram_read, m_data;
`ifdef BRAM_RD_LOOP_EN
    logic            loop;
`endif

    logic [DATA-1:0] mem [1 << ADDR];
    logic [7:0]      exp_q [$];
    int              total = 0;
    int              bad = 0;
    int              done_cnt = 0;
    int              d0;
    bit              stall_prev = 1'b0;
    bit              abort_prev = 1'b0;
    logic [7:0]      prev_data = '0;

    always #5 clk = ~clk;

    always @(posedge clk) ram_read <= mem[ram_addr];

    bram_stream_reader #(.ADDR(ADDR), .DATA(DATA)) dut (
        .clk      (clk),
        .nreset   (nreset),
        .start    (start),
        .base     (base),
        .len      (len),
        .abort    (abort),
`ifdef BRAM_RD_LOOP_EN
        .loop     (loop),
`endif
        .busy     (busy),
        .done     (done),
        .ram_addr (ram_addr),
        .ram_read (ram_read),
        .m_data   (m_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Stream monitor: scoreboard compare on every handshake, stability check after every stall.
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            if (stall_prev && !abort_prev)
                chk("hold", 32'({m_valid, m_data}), 32'({1'b1, prev_data}));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 32'(m_data), 32'hFFFF_FFFF);
                else                   chk("data", 32'(m_data), 32'(exp_q.pop_front()));
            end
            stall_prev = m_valid && !m_ready;
            prev_data  = m_data;
            abort_prev = abort;
            if (done) done_cnt++;
        end
    end

    task automatic do_start(input logic [ADDR-1:0] b, input logic [ADDR:0] l, input int npush);
        @(posedge clk); #1;
        start = 1'b1; base = b; len = l;
        for (int i = 0; i < npush; i++) exp_q.push_back(8'(int'(b) + i));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_until_idle(input int budget, input bit toggle);
        int n;
        for (n = 0; n < budget; n++) begin
            @(posedge clk); #1;
            if (toggle) m_ready = ~m_ready;
            @(negedge clk); #1;
            if (!busy) break;
        end
        if (n == budget) chk("timeout", 32'(1), 32'(0));
        @(negedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR); i++) mem[i] = 8'(i);
        nreset = 1'b0; start = 1'b0; abort = 1'b0; m_ready = 1'b1;
        base = '0; len = '0;
`ifdef BRAM_RD_LOOP_EN
        loop = 1'b0;
`endif
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy",  32'(busy),     32'(0));
        chk("rst_done",  32'(done),     32'(0));
        chk("rst_valid", 32'(m_valid),  32'(0));
        chk("rst_data",  32'(m_data),   32'(0));
        chk("rst_addr",  32'(ram_addr), 32'(0));
        @(posedge clk); #1;
        nreset = 1'b1;

        // Basic read with exact latency
        d0 = done_cnt;
        do_start(10'h010, 11'd4, 4);
        @(negedge clk);
        chk("t1_addr",   32'(ram_addr), 32'h010);
        chk("t1_busy",   32'(busy),     32'(1));
        chk("t1_v_k1",   32'(m_valid),  32'(0));
        @(negedge clk);
        chk("t1_v_k2",   32'(m_valid),  32'(0));
        for (int c = 3; c <= 6; c++) begin
            @(negedge clk);
            chk("t1_valid", 32'(m_valid), 32'(1));
            chk("t1_word",  32'(m_data),  32'(8'h0D + c));
        end
        @(negedge clk);
        chk("t1_done",     32'(done),    32'(1));
        chk("t1_busy_fin", 32'(busy),    32'(1));
        chk("t1_v_fin",    32'(m_valid), 32'(0));
        @(negedge clk);
        chk("t1_done_off", 32'(done), 32'(0));
        chk("t1_idle",     32'(busy), 32'(0));
        #1;
        chk("t1_pulses", 32'(done_cnt - d0), 32'(1));
        chk("t1_sb",     32'(exp_q.size()),  32'(0));

        // Address wrap, and a second start while busy must be ignored
        d0 = done_cnt;
        do_start(10'h3FE, 11'd4, 4);
        @(posedge clk); #1;
        start = 1'b1; base = 10'h200; len = 11'd5;
        @(posedge clk); #1;
        start = 1'b0;
        run_until_idle(40, 1'b0);
        chk("t2_pulses", 32'(done_cnt - d0), 32'(1));
        chk("t2_sb",     32'(exp_q.size()),  32'(0));

        // Backpressure with m_ready toggling every cycle
        d0 = done_cnt;
        do_start(10'h155, 11'd8, 8);
        run_until_idle(80, 1'b1);
        m_ready = 1'b1;
        chk("t3_pulses", 32'(done_cnt - d0), 32'(1));
        chk("t3_sb",     32'(exp_q.size()),  32'(0));

        // Zero-length transfer
        d0 = done_cnt;
        do_start(10'h077, 11'd0, 0);
        @(negedge clk);
        chk("t4_busy",  32'(busy),    32'(1));
        chk("t4_done",  32'(done),    32'(1));
        chk("t4_valid", 32'(m_valid), 32'(0));
        @(negedge clk);
        chk("t4_idle",  32'(busy), 32'(0));
        chk("t4_done2", 32'(done), 32'(0));
        #1;
        chk("t4_pulses", 32'(done_cnt - d0), 32'(1));

        // Abort and start together in IDLE: abort wins
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; base = 10'h030; len = 11'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("as_busy", 32'(busy), 32'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("as_valid", 32'(m_valid), 32'(0));
        end

        // Abort while the third word is stalled
        d0 = done_cnt;
        m_ready = 1'b1;
        do_start(10'h020, 11'd8, 2);
        repeat (4) @(posedge clk);
        #1;
        m_ready = 1'b0; abort = 1'b1;
        @(negedge clk);
        chk("t5_valid3", 32'(m_valid), 32'(1));
        chk("t5_word3",  32'(m_data),  32'h22);
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("t5_flush", 32'(m_valid), 32'(0));
        chk("t5_busy",  32'(busy),    32'(0));
        chk("t5_done",  32'(done),    32'(0));
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t5_late", 32'(m_valid), 32'(0));
        end
        #1;
        chk("t5_pulses", 32'(done_cnt - d0), 32'(0));
        chk("t5_sb",     32'(exp_q.size()),  32'(0));
        d0 = done_cnt;
        do_start(10'h100, 11'd2, 2);
        run_until_idle(30, 1'b0);
        chk("t5_restart", 32'(done_cnt - d0), 32'(1));
        chk("t5_sb2",     32'(exp_q.size()),  32'(0));

`ifdef BRAM_RD_LOOP_EN
        // Looping window: three passes of 4,5,6 then stop
        d0 = done_cnt;
        loop = 1'b1;
        for (int p = 0; p < 3; p++)
            for (int i = 4; i < 7; i++) exp_q.push_back(8'(i));
        do_start(10'h004, 11'd3, 0);
        repeat (7) @(posedge clk);
        #1;
        loop = 1'b0;
        run_until_idle(40, 1'b0);
        chk("t6_pulses", 32'(done_cnt - d0), 32'(3));
        chk("t6_sb",     32'(exp_q.size()),  32'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
